// File: rtl/lsu_data_if.sv
// lsu_data_if: core-side load/store initiator for the data-memory req/gnt/rvalid port.
// One access outstanding at a time. Store byte enables and lane-replicated write data are
// built per byte lane. Load data is aligned and extended on the way back. Misaligned or
// illegal accesses and memory timeouts complete with an error pulse.

// Per-byte-lane store formatting: picks this lane's enable and source byte for the access size.
module lsu_data_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] typ,
  input  logic [1:0] off,
  input  logic [7:0] byte_src,
  input  logic [7:0] half_src,
  input  logic [7:0] word_src,
  output logic       be,
  output logic [7:0] wbyte
);

  localparam logic [1:0] IDX = 2'(LANE);

  // Byte hits one lane and is replicated to all lanes.
  // Half hits the upper or lower lane pair, and the halfword is replicated.
  // Word hits every lane.
  always_comb begin
    be    = 1'b0;
    wbyte = word_src;
    case (typ)
      2'b00: begin
        be    = (off == IDX);
        wbyte = byte_src;
      end
      2'b01: begin
        be    = (off[1] == IDX[1]);
        wbyte = half_src;
      end
      2'b10: begin
        be    = 1'b1;
        wbyte = word_src;
      end
      default: ;
    endcase
  end

endmodule

module lsu_data_if #(
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      lsu_req_i,
  input  logic                      lsu_we_i,
  input  logic [1:0]                lsu_type_i,
  input  logic                      lsu_sign_ext_i,
  input  logic [31:0]               lsu_addr_i,
  input  logic [31:0]               lsu_wdata_i,
  output logic                      lsu_busy_o,
  output logic                      lsu_rvalid_o,
  output logic [31:0]               lsu_rdata_o,
  output logic                      lsu_err_o,
  output logic                      data_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] data_addr_o,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [31:0]               data_wdata_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  input  logic [31:0]               data_rdata_i
);

  localparam int NUM_LANES = 4;
  // The counter only ever has to reach TIMEOUT_CYCLES-1: that is the last wait cycle.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_GNT    = 3'd1,
    WAIT_RVALID = 3'd2,
    ERR         = 3'd3,
    DONE        = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic                          we_q;
  logic [1:0]                    type_q;
  logic                          sign_q;
  logic [1:0]                    off_q;
  logic [MEM_ADDR_WIDTH-1:0]     waddr_q;
  logic [3:0]                    be_q;
  logic [31:0]                   wdata_q;
  logic [31:0]                   rdata_q;
  logic [CNT_W-1:0]              cnt_q;

  logic                          accept;
  logic                          req_legal;
  logic                          tmo_hit;
  logic                          ld_cap;
  logic [NUM_LANES-1:0]          lane_be;
  logic [NUM_LANES-1:0][7:0]     lane_wdata;
  logic [31:0]                   ld_shift;
  logic [31:0]                   ld_ext;

  // Address bits above the data RAM's word index are not decoded.
  logic                          unused_addr_hi;
  assign unused_addr_hi = ^lsu_addr_i[31:MEM_ADDR_WIDTH+2];

  assign accept = (state_q == IDLE) && lsu_req_i;

  // Completion in the same cycle as the last allowed wait cycle wins over the abort.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // Load data is taken only on a real completion: a same-cycle gnt+rvalid, or rvalid after gnt.
  assign ld_cap = !we_q && data_rvalid_i &&
                  (((state_q == WAIT_GNT) && data_gnt_i) || (state_q == WAIT_RVALID));

  // Store formatting lanes work on the raw request, so the result is registered at capture.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lsu_data_lane #(.LANE(gi)) u_lane (
        .typ      (lsu_type_i),
        .off      (lsu_addr_i[1:0]),
        .byte_src (lsu_wdata_i[7:0]),
        .half_src (lsu_wdata_i[8*(gi%2) +: 8]),
        .word_src (lsu_wdata_i[8*gi +: 8]),
        .be       (lane_be[gi]),
        .wbyte    (lane_wdata[gi])
      );
    end
  endgenerate

  // Alignment check of the incoming request.
  always_comb begin
    req_legal = 1'b0;
    case (lsu_type_i)
      2'b00:   req_legal = 1'b1;
      2'b01:   req_legal = ~lsu_addr_i[0];
      2'b10:   req_legal = (lsu_addr_i[1:0] == 2'b00);
      default: req_legal = 1'b0;
    endcase
  end

  // Capture the request. All memory-side outputs come from these registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      type_q  <= 2'b00;
      sign_q  <= 1'b0;
      off_q   <= 2'b00;
      waddr_q <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= lsu_we_i;
      type_q  <= lsu_type_i;
      sign_q  <= lsu_sign_ext_i;
      off_q   <= lsu_addr_i[1:0];
      waddr_q <= lsu_addr_i[MEM_ADDR_WIDTH+1:2];
      be_q    <= req_legal ? lane_be : 4'b0000;
      wdata_q <= lane_wdata;
    end
  end

  // Timeout counter: cleared on request capture and advanced on every wait cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((TIMEOUT_CYCLES != 0) &&
                 ((state_q == WAIT_GNT) || (state_q == WAIT_RVALID))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Align the returned word to the accessed byte or halfword, then extend it.
  always_comb begin
    ld_shift = data_rdata_i;
    ld_ext   = data_rdata_i;
    case (type_q)
      2'b00: begin
        ld_shift = data_rdata_i >> {off_q, 3'b000};
        ld_ext   = {{24{sign_q & ld_shift[7]}}, ld_shift[7:0]};
      end
      2'b01: begin
        ld_shift = data_rdata_i >> {off_q[1], 4'b0000};
        ld_ext   = {{16{sign_q & ld_shift[15]}}, ld_shift[15:0]};
      end
      default: begin
        ld_shift = data_rdata_i;
        ld_ext   = ld_shift;
      end
    endcase
  end

  // Load result register. It is cleared per access, so stores and errors return zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'h0;
    end else if (accept) begin
      rdata_q <= 32'h0;
    end else if (ld_cap) begin
      rdata_q <= ld_ext;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state. gnt/rvalid are only looked at while an access is waiting on them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) state_d = req_legal ? WAIT_GNT : ERR;
      end
      WAIT_GNT: begin
        if (data_gnt_i && (we_q || data_rvalid_i)) state_d = DONE;
        else if (tmo_hit)                          state_d = ERR;
        else if (data_gnt_i)                       state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) state_d = DONE;
        else if (tmo_hit)  state_d = ERR;
      end
      ERR:     state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: all of them depend on state only, so reset clears them immediately.
  always_comb begin
    data_req_o   = 1'b0;
    lsu_busy_o   = 1'b1;
    lsu_rvalid_o = 1'b0;
    lsu_err_o    = 1'b0;
    lsu_rdata_o  = 32'h0;
    case (state_q)
      IDLE:     lsu_busy_o = 1'b0;
      WAIT_GNT: data_req_o = 1'b1;
      ERR: begin
        lsu_rvalid_o = 1'b1;
        lsu_err_o    = 1'b1;
      end
      DONE: begin
        lsu_rvalid_o = 1'b1;
        lsu_rdata_o  = rdata_q;
      end
      default: ;
    endcase
  end

  assign data_addr_o  = waddr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_data_if.sv
// tb_lsu_data_if: random and directed accesses. A word-array memory model answers the port
// with programmable gnt/rvalid delays. Expected responses are queued at issue and popped by
// an independent monitor.

module tb_lsu_data_if;

  localparam int AW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lsu_req_i = 1'b0, lsu_we_i = 1'b0, lsu_sign_ext_i = 1'b0;
  logic [1:0]    lsu_type_i = 2'b00;
  logic [31:0]   lsu_addr_i = 32'h0, lsu_wdata_i = 32'h0;
  logic          lsu_busy_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0]   lsu_rdata_o;
  logic          data_req_o, data_we_o;
  logic [AW-1:0] data_addr_o;
  logic [3:0]    data_be_o;
  logic [31:0]   data_wdata_o;
  logic          data_gnt_i, data_rvalid_i;
  logic [31:0]   data_rdata_i;

  always #5 clk = ~clk;

  lsu_data_if #(.MEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o), .data_req_o(data_req_o), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  rsp_t        exp_q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] slv_mem [32];

  // Memory model control, set per access by the driver.
  int          gnt_dly = 0;
  int          rv_dly = 0;
  bit          no_gnt = 1'b0;
  bit          stray_en = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wdata = '0;
  logic        exp_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: drives gnt/rvalid on the falling edge for the next rising edge.
  initial begin
    bit         seen, pend;
    int         gc, rc;
    logic [4:0] la;
    seen = 0; pend = 0; gc = 0; rc = 0; la = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      if (!rst_n) begin
        seen = 0; pend = 0;
      end else if (pend) begin
        rc--;
        if (rc == 0) begin
          data_rvalid_i = 1'b1;
          data_rdata_i = slv_mem[la];
          pend = 0;
        end
      end else if (data_req_o) begin
        check("req_addr", 32'(data_addr_o), 32'(exp_addr));
        check("req_be", 32'(data_be_o), 32'(exp_be));
        check("req_we", 32'(data_we_o), 32'(exp_we));
        check("req_wdata", data_wdata_o, exp_wdata);
        if (!seen) begin seen = 1; gc = gnt_dly; end
        if (!no_gnt) begin
          if (gc == 0) begin
            data_gnt_i = 1'b1;
            seen = 0;
            if (data_we_o) begin
              for (int i = 0; i < 4; i++)
                if (data_be_o[i]) slv_mem[data_addr_o][8*i +: 8] = data_wdata_o[8*i +: 8];
            end else if (rv_dly == 0) begin
              data_rvalid_i = 1'b1;
              data_rdata_i = slv_mem[data_addr_o];
            end else begin
              pend = 1; rc = rv_dly; la = data_addr_o;
            end
          end else begin
            gc--;
          end
        end
      end else begin
        seen = 0;
        if (stray_en && $urandom_range(7) == 0) data_gnt_i = 1'b1;
        if (stray_en && $urandom_range(7) == 0) begin
          data_rvalid_i = 1'b1;
          data_rdata_i = $urandom;
        end
      end
    end
  end

  // Response monitor: every completion pulse must match the oldest expectation.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && lsu_rvalid_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: got rvalid with rdata %h err %0d, required none",
                   lsu_rdata_o, lsu_err_o);
        end else begin
          e = exp_q.pop_front();
          check("rsp_err", 32'(lsu_err_o), 32'(e.err));
          check("rsp_rdata", lsu_rdata_o, e.rdata);
        end
      end
    end
  end

  // One access: model the expected result, present the request, time the completion.
  task automatic access(input logic we, input logic [1:0] typ, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gd, input int rd, input bit ng, input bit noise,
                        input string tag);
    logic [1:0]  off;
    logic [4:0]  w;
    bit          legal;
    rsp_t        e;
    int          lat, n;
    logic [31:0] v;
    off = addr[1:0];
    w = addr[6:2];
    legal = (typ == 2'b00) || (typ == 2'b01 && !off[0]) || (typ == 2'b10 && off == 2'b00);
    @(negedge clk);
    check({tag, "_idle"}, 32'(lsu_busy_o), 32'd0);
    exp_addr = w;
    exp_we = we;
    case (typ)
      2'b00:   begin exp_be = 4'b0001 << off; exp_wdata = {4{wd[7:0]}}; end
      2'b01:   begin exp_be = off[1] ? 4'b1100 : 4'b0011; exp_wdata = {2{wd[15:0]}}; end
      default: begin exp_be = 4'b1111; exp_wdata = wd; end
    endcase
    e.err = 1'b0;
    e.rdata = 32'h0;
    if (!legal) begin
      e.err = 1'b1; lat = 1;
    end else if (ng) begin
      e.err = 1'b1; lat = TO + 1;
    end else if (we) begin
      lat = 2 + gd;
      case (typ)
        2'b00:   ref_mem[w][8*off +: 8] = wd[7:0];
        2'b01:   ref_mem[w][16*off[1] +: 16] = wd[15:0];
        default: ref_mem[w] = wd;
      endcase
    end else begin
      lat = 2 + gd + rd;
      case (typ)
        2'b00: begin
          v = (ref_mem[w] >> (8 * off)) & 32'hFF;
          if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end
        2'b01: begin
          v = (ref_mem[w] >> (16 * off[1])) & 32'hFFFF;
          if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end
        default: v = ref_mem[w];
      endcase
      e.rdata = v;
    end
    exp_q.push_back(e);
    gnt_dly = gd; rv_dly = rd; no_gnt = ng;
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = typ; lsu_sign_ext_i = sgn;
    lsu_addr_i = addr; lsu_wdata_i = wd;
    @(negedge clk);
    lsu_req_i = 1'b0;
    n = 1;
    if (!legal) check({tag, "_illegal_noreq"}, 32'(data_req_o), 32'd0);
    while (!lsu_rvalid_o && n < 60) begin
      if (noise) begin
        lsu_req_i = 1'($urandom_range(1));
        lsu_we_i = 1'($urandom_range(1));
        lsu_type_i = 2'($urandom_range(3));
        lsu_addr_i = $urandom;
        lsu_wdata_i = $urandom;
      end
      @(negedge clk);
      n++;
    end
    lsu_req_i = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_req_low_at_rsp"}, 32'(data_req_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r = $urandom;
      ref_mem[i] = r;
      slv_mem[i] = r;
    end
    ref_mem[2] = 32'h8001_7F02;
    slv_mem[2] = 32'h8001_7F02;

    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'({lsu_busy_o, lsu_rvalid_o, lsu_err_o, data_req_o, data_we_o}), 32'd0);
    check("rst_be_addr", 32'({data_be_o, data_addr_o}), 32'd0);
    check("rst_rdata", lsu_rdata_o, 32'd0);
    check("rst_wdata", data_wdata_o, 32'd0);
    rst_n = 1'b1;

    access(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, 0, 1'b0, 1'b0, "ld_word");
    access(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 0, 0, 1'b0, 1'b0, "ld_byte_s");
    access(1'b0, 2'b00, 1'b0, 32'h0A, 32'h0, 1, 0, 1'b0, 1'b0, "ld_byte_u");
    access(1'b1, 2'b01, 1'b0, 32'h06, 32'h1234, 0, 0, 1'b0, 1'b0, "st_half");
    access(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 0, 0, 1'b0, 1'b0, "ld_after_st");
    access(1'b0, 2'b01, 1'b1, 32'h1E, 32'hFACE_0000, 3, 2, 1'b0, 1'b1, "ld_delay");
    access(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0, 0, 1'b0, 1'b0, "ill_word");
    access(1'b1, 2'b11, 1'b0, 32'h10, 32'h55, 0, 0, 1'b0, 1'b0, "ill_type");
    access(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 0, 0, 1'b0, 1'b0, "ill_half");
    access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 0, 1'b1, 1'b0, "timeout");
    access(1'b1, 2'b00, 1'b0, 32'h2D, 32'hA5, 7, 0, 1'b0, 1'b0, "st_last_cycle");
    access(1'b0, 2'b10, 1'b0, 32'h2C, 32'h0, 3, 4, 1'b0, 1'b0, "ld_last_cycle");

    // Reset in WAIT_GNT: req must drop without a clock edge, and no completion may follow.
    @(negedge clk);
    no_gnt = 1'b1;
    exp_addr = 5'd4; exp_be = 4'b1111; exp_we = 1'b0; exp_wdata = 32'h0;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b10; lsu_addr_i = 32'h10; lsu_wdata_i = 32'h0;
    @(negedge clk);
    lsu_req_i = 1'b0;
    @(negedge clk);
    check("pre_rst_req", 32'(data_req_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_req", 32'(data_req_o), 32'd0);
    check("async_rst_busy", 32'(lsu_busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_gnt = 1'b0;
    repeat (4) @(negedge clk);

    stray_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      access(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
             $urandom, $urandom, $urandom_range(3), $urandom_range(3), 1'b0,
             1'($urandom_range(1)), "rnd");
    end
    stray_en = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
